gg_ureg: RTL and testbench

GG_UREG -- requirements
Module: gg_ureg

---
 rtl/gg_ureg_pkg.sv | 15 +
 rtl/gg_ureg_next.sv | 66 ++++++
 rtl/gg_ureg.sv | 47 ++++
 tb/tb_gg_ureg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gg_ureg_pkg.sv
// Shared types for the gg_ureg universal register: the MODE operation encoding.
package gg_ureg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_INC  = 3'd4,
    MODE_DEC  = 3'd5,
    MODE_ROL  = 3'd6,
    MODE_ROR  = 3'd7
  } mode_e;

endpackage

// File: rtl/gg_ureg_next.sv
// Combinational next-state/next-CO computation for gg_ureg.
// Optional macro GG_UREG_SAT_EN makes INC/DEC saturate instead of wrapping.
module gg_ureg_next
  import gg_ureg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next,
  output logic             co_next,
  output logic             upd
);

  // Returns {carry, result}; carry is the WIDTH+1 bit of the widened sum.
  function automatic logic [WIDTH:0] inc_op(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] sum;
    sum = {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
`ifdef GG_UREG_SAT_EN
    if (sum[WIDTH]) return {1'b1, v};
`endif
    return sum;
  endfunction

  // Returns {borrow, result}; borrow shows up as the top bit going to 1.
  function automatic logic [WIDTH:0] dec_op(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] diff;
    diff = {1'b0, v} - {{WIDTH{1'b0}}, 1'b1};
`ifdef GG_UREG_SAT_EN
    if (diff[WIDTH]) return {1'b1, v};
`endif
    return diff;
  endfunction

  always_comb begin
    q_next  = q;
    co_next = 1'b0;
    upd     = 1'b1;
    case (mode)
      MODE_LOAD: q_next = d;
      MODE_SHL: begin
        q_next  = {q[WIDTH-2:0], sin};
        co_next = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {sin, q[WIDTH-1:1]};
        co_next = q[0];
      end
      MODE_INC: {co_next, q_next} = inc_op(q);
      MODE_DEC: {co_next, q_next} = dec_op(q);
      MODE_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        co_next = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        co_next = q[0];
      end
      // HOLD and any unknown encoding leave all state untouched
      default: upd = 1'b0;
    endcase
  end

endmodule

// File: rtl/gg_ureg.sv
// Universal register top: state flops, active-low enable and synchronous clear.
// Build option GG_UREG_SAT_EN selects saturating INC/DEC (see gg_ureg_next).
module gg_ureg
  import gg_ureg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             ZERO
);

  logic [WIDTH-1:0] q_next;
  logic             co_next;
  logic             upd;

  gg_ureg_next #(.WIDTH(WIDTH)) u_next (
    .q      (Q),
    .mode   (mode_e'(MODE)),
    .d      (D),
    .sin    (SIN),
    .q_next (q_next),
    .co_next(co_next),
    .upd    (upd)
  );

  // An X on EN makes the condition false, so the register holds
  always_ff @(posedge CK) begin
    if (CLR) begin
      Q    <= RESET_VAL;
      CO   <= 1'b0;
      ZERO <= (RESET_VAL == '0);
    end else if (!EN && upd) begin
      Q    <= q_next;
      CO   <= co_next;
      ZERO <= (q_next == '0);
    end
  end

endmodule

// File: tb/tb_gg_ureg.sv
// Directed bench for gg_ureg: an 8-bit instance (RESET_VAL=0) and a 16-bit one (RESET_VAL=A5A5).
module tb_gg_ureg;
  import gg_ureg_pkg::*;

`ifdef GG_UREG_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        CK = 1'b0;
  always #5 CK = ~CK;

  logic        clr8, en8, sin8;
  logic [2:0]  mode8;
  logic [7:0]  d8, q8;
  logic        co8, zero8;

  logic        clr16, en16, sin16;
  logic [2:0]  mode16;
  logic [15:0] d16, q16;
  logic        co16, zero16;

  int chk = 0;
  int err = 0;

  logic [7:0]  wq;
  logic [15:0] wq16;
  logic        wc, wz;

  gg_ureg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
    .CK(CK), .CLR(clr8), .EN(en8), .MODE(mode8), .D(d8), .SIN(sin8),
    .Q(q8), .CO(co8), .ZERO(zero8)
  );

  gg_ureg #(.WIDTH(16), .RESET_VAL(16'hA5A5)) dut16 (
    .CK(CK), .CLR(clr16), .EN(en16), .MODE(mode16), .D(d16), .SIN(sin16),
    .Q(q16), .CO(co16), .ZERO(zero16)
  );

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    clr8 = 1'b1; en8 = 1'b0; mode8 = MODE_LOAD; d8 = 8'h42; sin8 = 1'b0;
    tick();
    wq = 8'h00; wc = 1'b0; wz = 1'b1; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL reset: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    clr8 = 1'b0;
    tick();
    wq = 8'h42; wc = 1'b0; wz = 1'b0; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL load_after_reset: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
  endtask

  task automatic test_enable();
    en8 = 1'b1; mode8 = MODE_LOAD; d8 = 8'h99;
    tick();
    wq = 8'h42; wc = 1'b0; wz = 1'b0; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL en_hold: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    en8 = 1'b0;
    tick();
    wq = 8'h99; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL en_load: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
  endtask

  task automatic test_inc_dec();
    mode8 = MODE_LOAD; d8 = 8'hFF;
    tick();
    mode8 = MODE_INC;
    tick();
    wq = SAT ? 8'hFF : 8'h00; wc = 1'b1; wz = ~SAT; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL inc_ff: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    mode8 = MODE_LOAD; d8 = 8'h00;
    tick();
    mode8 = MODE_DEC;
    tick();
    wq = SAT ? 8'h00 : 8'hFF; wc = 1'b1; wz = SAT; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL dec_00: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    mode8 = MODE_LOAD; d8 = 8'h7F;
    tick();
    mode8 = MODE_INC;
    tick();
    wq = 8'h80; wc = 1'b0; wz = 1'b0; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL inc_7f: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    mode8 = MODE_LOAD; d8 = 8'h01;
    tick();
    mode8 = MODE_DEC;
    tick();
    wq = 8'h00; wc = 1'b0; wz = 1'b1; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL dec_01: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
  endtask

  task automatic test_shift();
    mode8 = MODE_LOAD; d8 = 8'h81;
    tick();
    mode8 = MODE_SHL; sin8 = 1'b0;
    tick();
    wq = 8'h02; wc = 1'b1; wz = 1'b0; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL shl: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    mode8 = MODE_ROR; sin8 = 1'b1;
    tick();
    wq = 8'h01; wc = 1'b0; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL ror1: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    tick();
    wq = 8'h80; wc = 1'b1; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL ror2: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    mode8 = MODE_SHR; sin8 = 1'b1;
    tick();
    wq = 8'hC0; wc = 1'b0; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL shr: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    mode8 = MODE_ROL; sin8 = 1'b0;
    tick();
    wq = 8'h81; wc = 1'b1; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL rol: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    mode8 = MODE_SHL; sin8 = 1'b1;
    tick();
    wq = 8'h03; wc = 1'b1; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL shl_sin1: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    mode8 = MODE_SHR; sin8 = 1'b0;
    tick();
    wq = 8'h01; wc = 1'b1; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL shr_sin0: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
  endtask

  task automatic test_hold();
    mode8 = MODE_LOAD; d8 = 8'hFF;
    tick();
    mode8 = MODE_INC;
    tick();
    mode8 = MODE_HOLD; d8 = 8'h3C;
    tick();
    wq = SAT ? 8'hFF : 8'h00; wc = 1'b1; wz = ~SAT; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL mode_hold: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    en8 = 1'b1; mode8 = MODE_SHL; sin8 = 1'b1;
    tick();
    chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL en_hold_co: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    clr8 = 1'b1;
    #3;
    chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL clr_no_edge: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    clr8 = 1'b0;
    tick();
    en8 = 1'b0;
  endtask

  task automatic test_clr_priority();
    mode8 = MODE_LOAD; d8 = 8'h55;
    tick();
    mode8 = MODE_INC; clr8 = 1'b1;
    tick();
    wq = 8'h00; wc = 1'b0; wz = 1'b1; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL clr_prio: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
    clr8 = 1'b0;
    tick();
    wq = 8'h01; wz = 1'b0; chk++;
    if ({q8, co8, zero8} !== {wq, wc, wz}) begin err++; $display("FAIL clr_recover: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q8, co8, zero8, wq, wc, wz); end
  endtask

  task automatic test_wide();
    en8 = 1'b1;
    clr16 = 1'b1; en16 = 1'b0; mode16 = MODE_LOAD; d16 = 16'h0042; sin16 = 1'b0;
    tick();
    wq16 = 16'hA5A5; wc = 1'b0; wz = 1'b0; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_reset: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    clr16 = 1'b0;
    tick();
    wq16 = 16'h0042; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_load: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    en16 = 1'b1; d16 = 16'h0099;
    tick();
    chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_en_hold: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    en16 = 1'b0; d16 = 16'hFFFF;
    tick();
    mode16 = MODE_INC;
    tick();
    wq16 = SAT ? 16'hFFFF : 16'h0000; wc = 1'b1; wz = ~SAT; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_inc_ffff: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    mode16 = MODE_LOAD; d16 = 16'h0000;
    tick();
    mode16 = MODE_DEC;
    tick();
    wq16 = SAT ? 16'h0000 : 16'hFFFF; wc = 1'b1; wz = SAT; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_dec_0000: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    mode16 = MODE_LOAD; d16 = 16'h8001;
    tick();
    mode16 = MODE_SHL; sin16 = 1'b0;
    tick();
    wq16 = 16'h0002; wc = 1'b1; wz = 1'b0; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_shl: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    mode16 = MODE_ROR;
    tick();
    tick();
    wq16 = 16'h8000; wc = 1'b1; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_ror2: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    mode16 = MODE_SHR; sin16 = 1'b1;
    tick();
    wq16 = 16'hC000; wc = 1'b0; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_shr: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    mode16 = MODE_LOAD; d16 = 16'h5555;
    tick();
    mode16 = MODE_INC; clr16 = 1'b1;
    tick();
    wq16 = 16'hA5A5; wc = 1'b0; wz = 1'b0; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_clr_prio: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
    clr16 = 1'b0;
    tick();
    wq16 = 16'hA5A6; chk++;
    if ({q16, co16, zero16} !== {wq16, wc, wz}) begin err++; $display("FAIL w_clr_recover: q=%h co=%b zero=%b want q=%h co=%b zero=%b", q16, co16, zero16, wq16, wc, wz); end
  endtask

  initial begin
    clr8 = 1'b0; en8 = 1'b1; mode8 = MODE_HOLD; d8 = 8'h00; sin8 = 1'b0;
    clr16 = 1'b0; en16 = 1'b1; mode16 = MODE_HOLD; d16 = 16'h0000; sin16 = 1'b0;
    test_reset();
    test_enable();
    test_inc_dec();
    test_shift();
    test_hold();
    test_clr_priority();
    test_wide();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
